// File: rtl/dense_head.sv
// rtl/dense_head.sv - RNN dense output head: hard-tanh clip, sequential MAC, bias, round/saturate
//
// Purpose:
//   Reads the hidden vector and dense weight vector one element per cycle
//   through a shared index (sel). Each hidden element is clipped to
//   [-1.0, +1.0] and multiplied by its weight. The products are summed in a
//   wide accumulator, the dense bias is added, and the sum is converted back
//   to signed 16-bit fixed point with round-half-up and saturation.
//
// Optional feature (macro DENSE_HARD_SIGMOID_EN):
//   When defined, the saturated result x is passed through a hard sigmoid
//   clamp((x >>> 2) + 0.5, 0, 1.0) in the OUT stage. When undefined, no
//   sigmoid logic is built.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begins one evaluation when ready is high
//   ready     out  high in IDLE only
//   busy      out  high whenever not IDLE
//   sel       out  element index to the hidden/dense stores (data returns one cycle later)
//   h_in      in   signed hidden element for the previous sel
//   w_in      in   signed dense weight for the previous sel
//   bias      in   signed dense bias, sampled in BIAS
//   data_out  out  signed result, held until the next valid
//   valid     out  one-cycle pulse when data_out updates
module dense_head #(
  parameter int LEN_BITS  = 4,
  parameter int LEN       = 4,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       ready,
  output logic                       busy,
  output logic [LEN_BITS-1:0]        sel,
  input  logic signed [15:0]         h_in,
  input  logic signed [15:0]         w_in,
  input  logic signed [15:0]         bias,
  output logic signed [15:0]         data_out,
  output logic                       valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_BIAS,
    S_OUT
  } state_e;

  localparam logic [LEN_BITS-1:0]     LAST_SEL = LEN_BITS'(LEN - 1);
  localparam logic signed [16:0]      CLIP_HI  = 17'sd1 <<< FRAC_BITS;
  localparam logic signed [16:0]      CLIP_LO  = -CLIP_HI;
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO   = -ACC_W'(32768);

  state_e                    state_q, state_d;
  logic [LEN_BITS-1:0]       sel_q, sel_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      dv_q, dv_d;       // h_in/w_in carry a real element this cycle
  logic signed [15:0]        data_q, data_d;
  logic                      valid_q, valid_d;

  logic signed [16:0]        h_ext;
  logic signed [16:0]        h_clip;
  logic signed [ACC_W-1:0]   h_wide;
  logic signed [ACC_W-1:0]   w_wide;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   bias_sh;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   scaled;
  logic signed [15:0]        sat_res;
  logic signed [15:0]        result;

  // Hard tanh on the incoming hidden element.
  always_comb begin
    h_ext = {h_in[15], h_in};
    if (h_ext > CLIP_HI) begin
      h_clip = CLIP_HI;
    end else if (h_ext < CLIP_LO) begin
      h_clip = CLIP_LO;
    end else begin
      h_clip = h_ext;
    end
  end

  // Operands are widened before the multiply so the product lands
  // sign-extended in accumulator width; the clip bounds keep it within 32 bits.
  assign h_wide  = {{(ACC_W-17){h_clip[16]}}, h_clip};
  assign w_wide  = {{(ACC_W-16){w_in[15]}}, w_in};
  assign prod    = h_wide * w_wide;
  assign bias_sh = {{(ACC_W-16){bias[15]}}, bias} <<< FRAC_BITS;

  // Round half up, drop the extra fraction bits, saturate to 16 bits.
  always_comb begin
    rnd_sum = acc_q + RND;
    scaled  = rnd_sum >>> FRAC_BITS;
    if (scaled > SAT_HI) begin
      sat_res = 16'sh7fff;
    end else if (scaled < SAT_LO) begin
      sat_res = -16'sh8000;
    end else begin
      sat_res = scaled[15:0];
    end
  end

`ifdef DENSE_HARD_SIGMOID_EN
  localparam logic signed [17:0] SIG_HALF = 18'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [17:0] SIG_ONE  = 18'sd1 <<< FRAC_BITS;

  logic signed [17:0] sig_sum;

  always_comb begin
    sig_sum = {{4{sat_res[15]}}, sat_res[15:2]} + SIG_HALF;
    if (sig_sum < 18'sd0) begin
      result = 16'sd0;
    end else if (sig_sum > SIG_ONE) begin
      result = SIG_ONE[15:0];
    end else begin
      result = sig_sum[15:0];
    end
  end
`else
  assign result = sat_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      acc_q   <= '0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    dv_d    = dv_q;
    data_d  = data_q;
    valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          sel_d   = '0;
          dv_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The first RUN cycle has no returned data yet; after that, each
        // cycle delivers the element addressed one cycle earlier.
        if (dv_q) begin
          acc_d = acc_q + prod;
        end
        dv_d = 1'b1;
        if (sel_q == LAST_SEL) begin
          state_d = S_DRAIN;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + prod;
        state_d = S_BIAS;
      end
      S_BIAS: begin
        acc_d   = acc_q + bias_sh;
        state_d = S_OUT;
      end
      S_OUT: begin
        data_d  = result;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = valid_q;

endmodule
